apb4_mem_slave: RTL and testbench

Parametrised APB4 completer wrapping a single-port register-array memory. It is the next generation of our APB slave, adding configurable data/address width and depth, programmable wait states, PSTRB byte-lane writes, and a PPROT-gated privileged region. It adds PSLVERR on illegal accesses and reports protocol violations. It sits behind the APB interface as the DUT for the memory environment.

---
 rtl/apb4_mem_slave.sv | 175 +++++++++++++++++
 tb/tb_apb4_mem_slave.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_mem_slave.sv
// APB4 completer wrapping a single-port register-array memory with byte strobes and a privileged low region.
// Latency: setup phase plus WAIT_STATES+1 access cycles; PREADY/PRDATA/PSLVERR are registered.
// Backpressure: PREADY held low for WAIT_STATES access cycles; a new setup is accepted right after completion.
//
// Ports: PCLK/PRESET (async, active-high), APB4 completer signals PSEL..PPROT in, PREADY/PRDATA/PSLVERR out,
//        prot_viol: one-cycle pulse when the requester breaks APB sequencing rules.
module apb4_mem_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int PRIV_WORDS  = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR,
    output logic                    prot_viol
);
    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int ALIGN_BITS = $clog2(STRB_W);
    localparam int MEM_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
    // One extra bit so DEPTH == 2**ADDR_WIDTH (8-bit data) is still representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_L    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   PRIV_L     = (ADDR_WIDTH + 1)'(PRIV_WORDS);
    localparam logic [3:0]            WAIT_L     = 4'(WAIT_STATES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              cnt, cnt_nxt;
    logic                    ready_nxt, slverr_nxt, viol_nxt;
    logic [DATA_WIDTH-1:0]   rdata_nxt;

    // Setup-phase attributes, held for the whole access phase.
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       strb_q;
    logic                    prot0_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Only the privileged bit of PPROT matters here.
    logic unused_prot;
    assign unused_prot = ^PPROT[2:1];

    // With zero wait states the response is formed on the setup edge from the live bus;
    // otherwise it is formed from the captured copy.
    logic [ADDR_WIDTH-1:0]   eff_addr, eff_idx;
    logic                    eff_write, eff_prot0;
    logic                    acc_err;
    logic [DATA_WIDTH-1:0]   rd_word;

    assign eff_addr  = (state == IDLE) ? PADDR  : addr_q;
    assign eff_write = (state == IDLE) ? PWRITE : write_q;
    assign eff_prot0 = (state == IDLE) ? PPROT[0] : prot0_q;
    assign eff_idx   = eff_addr >> ALIGN_BITS;

    assign acc_err = ((eff_addr & ALIGN_MASK) != '0)
                   || ({1'b0, eff_idx} >= DEPTH_L)
                   || (eff_write && ({1'b0, eff_idx} < PRIV_L) && !eff_prot0);

    assign rd_word = (acc_err || eff_write) ? '0 : mem[eff_idx[MEM_AW-1:0]];

    logic setup, idle_viol, complete, abort, chg_viol;
    assign setup     = (state == IDLE) && PSEL && !PENABLE;
    assign idle_viol = (state == IDLE) && PSEL && PENABLE;
    assign complete  = (state == ACCESS) && PSEL && PENABLE && PREADY;
    assign abort     = (state == ACCESS) && !PSEL;
    assign chg_viol  = (state == ACCESS) && PSEL &&
                       ((PADDR != addr_q) || (PWRITE != write_q) ||
                        (PWDATA != wdata_q) || (PSTRB != strb_q));

    // State register (outputs are registered alongside).
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            PREADY    <= 1'b0;
            PRDATA    <= '0;
            PSLVERR   <= 1'b0;
            prot_viol <= 1'b0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prot0_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            PREADY    <= ready_nxt;
            PRDATA    <= rdata_nxt;
            PSLVERR   <= slverr_nxt;
            prot_viol <= viol_nxt;
            if (setup) begin
                addr_q  <= PADDR;
                write_q <= PWRITE;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
                prot0_q <= PPROT[0];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (setup) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = WAIT_L;
                end
            end
            ACCESS: begin
                if (abort || complete) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (!PREADY) begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic (next values of the registered outputs).
    always_comb begin
        ready_nxt  = PREADY;
        rdata_nxt  = PRDATA;
        slverr_nxt = PSLVERR;
        viol_nxt   = idle_viol || abort || chg_viol;
        unique case (state)
            IDLE: begin
                if (setup) begin
                    ready_nxt  = (WAIT_L == 4'd0);
                    rdata_nxt  = (WAIT_L == 4'd0) ? rd_word : '0;
                    slverr_nxt = (WAIT_L == 4'd0) && acc_err;
                end
            end
            ACCESS: begin
                if (abort || complete) begin
                    ready_nxt  = 1'b0;
                    rdata_nxt  = '0;
                    slverr_nxt = 1'b0;
                end else if (!PREADY && cnt == 4'd1) begin
                    ready_nxt  = 1'b1;
                    rdata_nxt  = rd_word;
                    slverr_nxt = acc_err;
                end
            end
            default: ;
        endcase
    end

    // Memory: writes commit only on the completion edge, per enabled byte lane.
    always_ff @(posedge PCLK) begin
        if (complete && write_q && !acc_err) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (strb_q[i]) mem[eff_idx[MEM_AW-1:0]][i*8 +: 8] <= wdata_q[i*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_apb4_mem_slave.sv
module tb_apb4_mem_slave;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        psel0, psel3;
    logic        PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;

    logic        ready0, err0, viol0;
    logic [31:0] rdata0;
    logic        ready3, err3, viol3;
    logic [31:0] rdata3;

    int checks = 0;
    int errors = 0;
    int vc0 = 0;
    int vc3 = 0;

    always #5 PCLK = ~PCLK;

    apb4_mem_slave #(.WAIT_STATES(0)) u_ws0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(ready0), .PRDATA(rdata0), .PSLVERR(err0), .prot_viol(viol0));

    apb4_mem_slave #(.WAIT_STATES(3)) u_ws3 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel3), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(ready3), .PRDATA(rdata3), .PSLVERR(err3), .prot_viol(viol3));

    always @(negedge PCLK) begin
        if (viol0) vc0++;
        if (viol3) vc3++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int t);
        return (t == 0) ? ready0 : ready3;
    endfunction

    // Caller is just after a rising edge. Returns after the completion edge with the bus idle.
    task automatic xfer(input int tgt, input logic wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p,
                        output logic [31:0] rd, output logic er, output int cyc);
        PADDR = a; PWRITE = wr; PWDATA = d; PSTRB = s; PPROT = p; PENABLE = 1'b0;
        psel0 = (tgt == 0); psel3 = (tgt == 3);
        rd = '0; er = 1'b0; cyc = 0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc++;
            @(negedge PCLK);
            if (rdy(tgt)) begin
                rd = (tgt == 0) ? rdata0 : rdata3;
                er = (tgt == 0) ? err0 : err3;
                break;
            end
            @(posedge PCLK); #1;
        end
        @(posedge PCLK); #1;
        psel0 = 1'b0; psel3 = 1'b0; PENABLE = 1'b0;
    endtask

    // Wait (bounded) for PREADY on the given instance; sits on the negedge where it is seen.
    task automatic wait_ready(input int tgt, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge PCLK);
            if (rdy(tgt)) seen = 1'b1;
            else begin @(posedge PCLK); #1; end
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [2:0]  p;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[24];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;
        int          v;
        logic        seen;

        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;
        int          v;
        logic        seen;

        vt[0]  = '{1'b1, 12'h040, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 12'h040, 32'h0,        4'h0, 3'b000, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 12'h080, 32'h11223344, 4'hF, 3'b000, 32'h0,        1'b0};
        vt[3]  = '{1'b1, 12'h080, 32'hAABBCCDD, 4'h5, 3'b000, 32'h0,        1'b0};
        vt[4]  = '{1'b0, 12'h080, 32'h0,        4'h0, 3'b000, 32'h11BB33DD, 1'b0};
        vt[5]  = '{1'b0, 12'h402, 32'h0,        4'h0, 3'b000, 32'h0,        1'b1};
        vt[6]  = '{1'b0, 12'h041, 32'h0,        4'h0, 3'b000, 32'h0,        1'b1};
        vt[7]  = '{1'b1, 12'h042, 32'hFFFFFFFF, 4'hF, 3'b000, 32'h0,        1'b1};
        vt[8]  = '{1'b0, 12'h040, 32'h0,        4'h0, 3'b000, 32'hDEADBEEF, 1'b0};
        vt[9]  = '{1'b0, 12'h400, 32'h0,        4'h0, 3'b000, 32'h0,        1'b1};
        vt[10] = '{1'b1, 12'h004, 32'h0BADF00D, 4'hF, 3'b001, 32'h0,        1'b0};
        vt[11] = '{1'b1, 12'h004, 32'h12345678, 4'hF, 3'b000, 32'h0,        1'b1};
        vt[12] = '{1'b0, 12'h004, 32'h0,        4'h0, 3'b000, 32'h0BADF00D, 1'b0};
        vt[13] = '{1'b1, 12'h004, 32'h12345678, 4'hF, 3'b001, 32'h0,        1'b0};
        vt[14] = '{1'b0, 12'h004, 32'h0,        4'h0, 3'b000, 32'h12345678, 1'b0};
        vt[15] = '{1'b1, 12'h03C, 32'hA5A5A5A5, 4'hF, 3'b001, 32'h0,        1'b0};
        vt[16] = '{1'b1, 12'h03C, 32'h00000000, 4'hF, 3'b000, 32'h0,        1'b1};
        vt[17] = '{1'b0, 12'h03C, 32'h0,        4'h0, 3'b000, 32'hA5A5A5A5, 1'b0};
        vt[18] = '{1'b1, 12'h0FC, 32'hCAFEBABE, 4'hF, 3'b000, 32'h0,        1'b0};
        vt[19] = '{1'b1, 12'h0FC, 32'h00000000, 4'h0, 3'b000, 32'h0,        1'b0};
        vt[20] = '{1'b0, 12'h0FC, 32'h0,        4'h0, 3'b000, 32'hCAFEBABE, 1'b0};
        vt[21] = '{1'b1, 12'h3FC, 32'h01020304, 4'hF, 3'b000, 32'h0,        1'b0};
        vt[22] = '{1'b0, 12'h3FC, 32'h0,        4'h0, 3'b000, 32'h01020304, 1'b0};
        vt[23] = '{1'b1, 12'h400, 32'h11111111, 4'hF, 3'b000, 32'h0,        1'b1};

        PRESET = 1'b1; psel0 = 1'b0; psel3 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0;

        // Reset state
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset_ready0", 32'(ready0), 32'd0);
        chk("reset_err0",   32'(err0),   32'd0);
        chk("reset_rdata0", rdata0,      32'd0);
        chk("reset_viol0",  32'(viol0),  32'd0);
        chk("reset_ready3", 32'(ready3), 32'd0);
        chk("reset_rdata3", rdata3,      32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // Back-to-back table on the zero-wait instance
        v = vc0;
        for (int i = 0; i < 24; i++) begin
            xfer(0, vt[i].wr, vt[i].a, vt[i].d, vt[i].s, vt[i].p, rd, er, cyc);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'd1);
            if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
        end
        chk("table_no_viol", 32'(vc0 - v), 32'd0);

        // Three wait states: ready on the 4th access cycle only
        xfer(3, 1'b1, 12'h100, 32'h13579BDF, 4'hF, 3'b000, rd, er, cyc);
        chk("ws3_write_cycles", 32'(cyc), 32'd4);
        chk("ws3_write_err", 32'(er), 32'd0);
        xfer(3, 1'b0, 12'h100, 32'h0, 4'h0, 3'b000, rd, er, cyc);
        chk("ws3_read_cycles", 32'(cyc), 32'd4);
        chk("ws3_read_rdata", rd, 32'h13579BDF);
        @(negedge PCLK);
        chk("ws3_ready_drops", 32'(ready3), 32'd0);
        @(posedge PCLK); #1;
        xfer(3, 1'b1, 12'h104, 32'h0F0F0F0F, 4'hF, 3'b000, rd, er, cyc);

        // Address changed during access: captured setup address is used
        v = vc3;
        PADDR = 12'h100; PWRITE = 1'b0; PWDATA = '0; PSTRB = '0; PPROT = '0;
        psel3 = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; PADDR = 12'h104;
        wait_ready(3, "chg_ready");
        chk("chg_rdata", rdata3, 32'h13579BDF);
        @(posedge PCLK); #1;
        psel3 = 1'b0; PENABLE = 1'b0; PADDR = 12'h100;
        @(negedge PCLK); #1;
        chk("chg_viol_seen", 32'(vc3 != v), 32'd1);
        @(posedge PCLK); #1;

        // Reset while a write is ready to complete
        xfer(3, 1'b1, 12'h200, 32'h600DCAFE, 4'hF, 3'b000, rd, er, cyc);
        PADDR = 12'h200; PWRITE = 1'b1; PWDATA = 32'hBAD0BAD0; PSTRB = 4'hF; PPROT = '0;
        psel3 = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        wait_ready(3, "rstw_ready");
        #1 PRESET = 1'b1;
        #1;
        chk("rstw_ready_low", 32'(ready3), 32'd0);
        chk("rstw_err_low", 32'(err3), 32'd0);
        chk("rstw_rdata_low", rdata3, 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0; psel3 = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        xfer(3, 1'b0, 12'h200, 32'h0, 4'h0, 3'b000, rd, er, cyc);
        chk("rstw_readback", rd, 32'h600DCAFE);

        // Reset while read data is being presented
        PADDR = 12'h200; PWRITE = 1'b0; PWDATA = '0; PSTRB = '0;
        psel3 = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        wait_ready(3, "rstr_ready");
        chk("rstr_rdata_before", rdata3, 32'h600DCAFE);
        #1 PRESET = 1'b1;
        #1;
        chk("rstr_rdata_low", rdata3, 32'd0);
        chk("rstr_ready_low", 32'(ready3), 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0; psel3 = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;

        // PENABLE without a setup phase
        v = vc0;
        psel0 = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 12'h040; PWDATA = 32'h0; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        psel0 = 1'b0; PENABLE = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            if (ready0) seen = 1'b1;
        end
        #1;
        chk("noset_no_ready", 32'(seen), 32'd0);
        chk("noset_viol_once", 32'(vc0 - v), 32'd1);
        @(posedge PCLK); #1;
        xfer(0, 1'b0, 12'h040, 32'h0, 4'h0, 3'b000, rd, er, cyc);
        chk("noset_mem_kept", rd, 32'hDEADBEEF);
        chk("noset_next_cycles", 32'(cyc), 32'd1);

        // PSEL dropped during a wait state
        xfer(3, 1'b1, 12'h300, 32'h12121212, 4'hF, 3'b000, rd, er, cyc);
        v = vc3;
        PADDR = 12'h300; PWRITE = 1'b1; PWDATA = 32'h77777777; PSTRB = 4'hF;
        psel3 = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        psel3 = 1'b0; PENABLE = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            if (ready3) seen = 1'b1;
        end
        #1;
        chk("drop_no_ready", 32'(seen), 32'd0);
        chk("drop_viol_once", 32'(vc3 - v), 32'd1);
        @(posedge PCLK); #1;
        xfer(3, 1'b0, 12'h300, 32'h0, 4'h0, 3'b000, rd, er, cyc);
        chk("drop_no_write", rd, 32'h12121212);
        chk("drop_next_cycles", 32'(cyc), 32'd4);
        chk("drop_next_err", 32'(er), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
